// File: rtl/dma_mem_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dma_mem_responder_pkg                                     |
// | Purpose  : Shared register offsets, CTRL fields, FSM state encoding  |
// |            and the byte-lane merge helper for the DMA responder.     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package dma_mem_responder_pkg;

  // Register byte offsets inside the peripheral window
  localparam logic [2:0] c_off_win_lo = 3'd0;
  localparam logic [2:0] c_off_win_hi = 3'd2;
  localparam logic [2:0] c_off_ctrl   = 3'd4;
  localparam logic [2:0] c_off_stall  = 3'd6;

  // CTRL layout: [3:0] wait states, [4] window enable
  localparam int          c_ctrl_win_en_bit = 4;
  localparam logic [15:0] c_ctrl_mask       = 16'h001F;

  // Request handshake states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_GRANT = 2'd2
  } dma_state_t;

  // Apply a 16-bit write honouring the two byte enables
  function automatic logic [15:0] byte_merge(input logic [15:0] old_val,
                                             input logic [15:0] new_val,
                                             input logic [1:0]  be);
    byte_merge = {be[1] ? new_val[15:8] : old_val[15:8],
                  be[0] ? new_val[7:0]  : old_val[7:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/dma_mem_responder_regs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dma_mem_responder_regs                                    |
// | Purpose  : Peripheral-bus decoder and WIN_LO/WIN_HI/CTRL/STALL regs  |
// |            for the DMA memory responder.                             |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module dma_mem_responder_regs
  import dma_mem_responder_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR  = 15'h0078,
  parameter int          DEC_WD     = 3,
  parameter logic [3:0]  WS_DEFAULT = 4'd0
) (
  input  logic        mclk,
  input  logic        puc_rst,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  input  logic        stall_inc,
  output logic [15:0] per_dout,
  output logic [15:0] win_lo,
  output logic [15:0] win_hi,
  output logic [3:0]  ctrl_ws,
  output logic        ctrl_win_en
);

  logic [15:0]       r_win_lo;
  logic [15:0]       r_win_hi;
  logic [15:0]       r_ctrl;
  logic [15:0]       r_stall;
  logic              w_sel;
  logic              w_wr;
  logic              w_rd;
  logic [DEC_WD-1:0] w_off;

  assign w_sel = per_en & (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
  assign w_off = {per_addr[DEC_WD-2:0], 1'b0};
  assign w_wr  = w_sel & (|per_we);
  assign w_rd  = w_sel & ~(|per_we);

  // Configuration registers, byte-lane writable
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      r_win_lo <= 16'h0000;
      r_win_hi <= 16'hFFFF;
      r_ctrl   <= {12'h000, WS_DEFAULT};
    end else if (w_wr) begin
      if (w_off == DEC_WD'(c_off_win_lo)) r_win_lo <= byte_merge(r_win_lo, per_din, per_we);
      if (w_off == DEC_WD'(c_off_win_hi)) r_win_hi <= byte_merge(r_win_hi, per_din, per_we);
      if (w_off == DEC_WD'(c_off_ctrl))   r_ctrl   <= byte_merge(r_ctrl, per_din, per_we) & c_ctrl_mask;
    end
  end

  // Stall counter: saturating, cleared by any write, clear beats increment
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      r_stall <= 16'h0000;
    end else if (w_wr && (w_off == DEC_WD'(c_off_stall))) begin
      r_stall <= 16'h0000;
    end else if (stall_inc && (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  // Read mux, zero when this block is not addressed
  always_comb begin
    per_dout = 16'h0000;
    if (w_rd) begin
      if (w_off == DEC_WD'(c_off_win_lo)) per_dout = r_win_lo;
      if (w_off == DEC_WD'(c_off_win_hi)) per_dout = r_win_hi;
      if (w_off == DEC_WD'(c_off_ctrl))   per_dout = r_ctrl;
      if (w_off == DEC_WD'(c_off_stall))  per_dout = r_stall;
    end
  end

  assign win_lo      = r_win_lo;
  assign win_hi      = r_win_hi;
  assign ctrl_ws     = r_ctrl[3:0];
  assign ctrl_win_en = r_ctrl[c_ctrl_win_en_bit];

endmodule
`default_nettype wire

// File: rtl/dma_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dma_mem_responder                                         |
// | Purpose  : openMSP430 DMA target serving a private single-port RAM,  |
// |            with wait states, CPU contention and window errors.       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module dma_mem_responder
  import dma_mem_responder_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR  = 15'h0078,
  parameter int          DEC_WD     = 3,
  parameter logic [15:0] DMEM_BASE  = 16'h0200,
  parameter int          DMEM_AW    = 10,
  parameter logic [3:0]  WS_DEFAULT = 4'd0
) (
  input  logic               mclk,
  input  logic               puc_rst,
  input  logic [13:0]        per_addr,
  input  logic [15:0]        per_din,
  input  logic               per_en,
  input  logic [1:0]         per_we,
  output logic [15:0]        per_dout,
  input  logic [14:0]        dma_addr,
  input  logic [15:0]        dma_din,
  input  logic               dma_en,
  input  logic [1:0]         dma_we,
  input  logic               dma_priority,
  output logic [15:0]        dma_dout,
  output logic               dma_ready,
  output logic               dma_resp,
  input  logic               cpu_dmem_busy,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic               dmem_cen,
  output logic [1:0]         dmem_wen,
  output logic [15:0]        dmem_din,
  input  logic [15:0]        dmem_dout
);

  // One past the last RAM byte, kept 17 bits wide so the compare is exact
  localparam logic [16:0] c_dmem_end = {1'b0, DMEM_BASE} + (17'd1 << (DMEM_AW + 1));

  dma_state_t  r_state;
  dma_state_t  w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        w_grant_phase;
  logic        w_arb_ok;
  logic        w_accept;
  logic        w_err;
  logic        w_access;
  logic [15:0] w_baddr;
  logic [15:0] w_win_lo;
  logic [15:0] w_win_hi;
  logic [3:0]  w_ws;
  logic        w_win_en;
  logic        r_resp;
  logic        r_rd_pend;
  logic        r_rd_err;
  logic [15:0] r_dout;
  logic [15:0] w_dout;

  dma_mem_responder_regs #(
    .BASE_ADDR  (BASE_ADDR),
    .DEC_WD     (DEC_WD),
    .WS_DEFAULT (WS_DEFAULT)
  ) u_regs (
    .mclk        (mclk),
    .puc_rst     (puc_rst),
    .per_addr    (per_addr),
    .per_din     (per_din),
    .per_en      (per_en),
    .per_we      (per_we),
    .stall_inc   (dma_en & ~dma_ready),
    .per_dout    (per_dout),
    .win_lo      (w_win_lo),
    .win_hi      (w_win_hi),
    .ctrl_ws     (w_ws),
    .ctrl_win_en (w_win_en)
  );

  // The CPU port wins unless the DMA request is marked high priority
  assign w_arb_ok = dma_en & (~cpu_dmem_busy | dma_priority);

  // Next-state and grant phase; a zero-wait request or an expired countdown grants in the same cycle
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_grant_phase = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (dma_en) begin
          if (w_ws == 4'd0) begin
            w_grant_phase = 1'b1;
            if (!w_arb_ok) w_state_nxt = ST_GRANT;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = w_ws - 4'd1;
          end
        end
      end
      ST_WAIT: begin
        if (!dma_en) begin
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_grant_phase = 1'b1;
          w_state_nxt   = w_arb_ok ? ST_IDLE : ST_GRANT;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_GRANT: begin
        w_grant_phase = 1'b1;
        if (!dma_en || w_arb_ok) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Handshake state register
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Reset forces ready low at once, which also drops every RAM strobe
  assign dma_ready = w_grant_phase & w_arb_ok & ~puc_rst;
  assign w_accept  = dma_en & dma_ready;

  assign w_baddr  = {dma_addr, 1'b0};
  assign w_err    = (w_win_en & ((w_baddr < w_win_lo) | (w_baddr >= w_win_hi)))
                  | (w_baddr < DMEM_BASE)
                  | ({1'b0, w_baddr} >= c_dmem_end);
  assign w_access = w_accept & ~w_err;

  assign dmem_cen  = ~w_access;
  assign dmem_wen  = w_access ? ~dma_we : 2'b11;
  assign dmem_din  = dma_din;
  assign dmem_addr = DMEM_AW'(dma_addr - DMEM_BASE[15:1]);

  // Read data is taken straight from the RAM in the cycle after the accept, then held
  assign w_dout   = r_rd_pend ? dmem_dout : (r_rd_err ? 16'h0000 : r_dout);
  assign dma_dout = w_dout;
  assign dma_resp = r_resp;

  // Response flags and read-data holding register
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      r_resp    <= 1'b0;
      r_rd_pend <= 1'b0;
      r_rd_err  <= 1'b0;
      r_dout    <= 16'h0000;
    end else begin
      r_resp    <= w_accept & w_err;
      r_rd_pend <= w_access & (dma_we == 2'b00);
      r_rd_err  <= w_accept & w_err & (dma_we == 2'b00);
      r_dout    <= w_dout;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dma_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_dma_mem_responder                                      |
// | Purpose  : Directed self-checking bench for dma_mem_responder.       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_dma_mem_responder;

  localparam logic [13:0] c_per_base_w = 14'h003C;

  logic        mclk = 1'b0;
  logic        puc_rst;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;
  logic [14:0] dma_addr;
  logic [15:0] dma_din;
  logic        dma_en;
  logic [1:0]  dma_we;
  logic        dma_priority;
  logic [15:0] dma_dout;
  logic        dma_ready;
  logic        dma_resp;
  logic        cpu_dmem_busy;
  logic [9:0]  dmem_addr;
  logic        dmem_cen;
  logic [1:0]  dmem_wen;
  logic [15:0] dmem_din;
  logic [15:0] dmem_dout;

  logic        tb_load;
  logic [15:0] mem [0:1023];

  int n_tests = 0;
  int n_fail  = 0;

  dma_mem_responder u_dut (
    .mclk          (mclk),
    .puc_rst       (puc_rst),
    .per_addr      (per_addr),
    .per_din       (per_din),
    .per_en        (per_en),
    .per_we        (per_we),
    .per_dout      (per_dout),
    .dma_addr      (dma_addr),
    .dma_din       (dma_din),
    .dma_en        (dma_en),
    .dma_we        (dma_we),
    .dma_priority  (dma_priority),
    .dma_dout      (dma_dout),
    .dma_ready     (dma_ready),
    .dma_resp      (dma_resp),
    .cpu_dmem_busy (cpu_dmem_busy),
    .dmem_addr     (dmem_addr),
    .dmem_cen      (dmem_cen),
    .dmem_wen      (dmem_wen),
    .dmem_din      (dmem_din),
    .dmem_dout     (dmem_dout)
  );

  always #5 mclk = ~mclk;

  // Single-port RAM with one-cycle read latency; tb_load seeds word 2
  always @(posedge mclk) begin
    if (tb_load) mem[2] <= 16'hBEEF;
    if (!dmem_cen) begin
      if (!dmem_wen[0]) mem[dmem_addr][7:0]  <= dmem_din[7:0];
      if (!dmem_wen[1]) mem[dmem_addr][15:8] <= dmem_din[15:8];
      dmem_dout <= mem[dmem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic per_wr(input logic [2:0] off, input logic [15:0] d);
    per_en   = 1'b1;
    per_we   = 2'b11;
    per_addr = c_per_base_w + 14'(off >> 1);
    per_din  = d;
    tick();
    per_en   = 1'b0;
    per_we   = 2'b00;
  endtask

  task automatic per_rd(input logic [2:0] off, output logic [15:0] d);
    per_en   = 1'b1;
    per_we   = 2'b00;
    per_addr = c_per_base_w + 14'(off >> 1);
    @(negedge mclk);
    d = per_dout;
    tick();
    per_en   = 1'b0;
  endtask

  // Zero-wait read: samples the accept cycle and the cycle after
  task automatic dma_rd(input logic [15:0] baddr, output logic rdy, output logic cen,
                        output logic resp, output logic [15:0] dout);
    dma_en   = 1'b1;
    dma_we   = 2'b00;
    dma_addr = baddr[15:1];
    @(negedge mclk);
    rdy = dma_ready;
    cen = dmem_cen;
    tick();
    dma_en = 1'b0;
    @(negedge mclk);
    resp = dma_resp;
    dout = dma_dout;
    tick();
  endtask

  logic [15:0] rd;
  logic        s_rdy, s_cen, s_resp;
  logic [15:0] s_dout;
  int          cycles;

  initial begin
    puc_rst = 1'b1; tb_load = 1'b1;
    per_addr = '0; per_din = '0; per_en = 1'b0; per_we = 2'b00;
    dma_addr = '0; dma_din = '0; dma_en = 1'b0; dma_we = 2'b00;
    dma_priority = 1'b0; cpu_dmem_busy = 1'b0;
    tick(); tick();
    // reset values, with a request pending to prove it is ignored
    dma_en = 1'b1; dma_addr = 15'h0102;
    @(negedge mclk);
    check("rst_ready", 32'(dma_ready), 32'd0);
    check("rst_cen",   32'(dmem_cen),  32'd1);
    check("rst_wen",   32'(dmem_wen),  32'd3);
    check("rst_resp",  32'(dma_resp),  32'd0);
    check("rst_dout",  32'(dma_dout),  32'd0);
    check("rst_pdout", 32'(per_dout),  32'd0);
    dma_en = 1'b0; tb_load = 1'b0;
    tick();
    puc_rst = 1'b0;
    tick();

    // WS=0 read of 0x0204
    dma_en = 1'b1; dma_we = 2'b00; dma_addr = 15'h0102;
    @(negedge mclk);
    check("t1_ready", 32'(dma_ready), 32'd1);
    check("t1_cen",   32'(dmem_cen),  32'd0);
    check("t1_addr",  32'(dmem_addr), 32'd2);
    tick();
    dma_en = 1'b0;
    @(negedge mclk);
    check("t1_dout", 32'(dma_dout), 32'hBEEF);
    check("t1_resp", 32'(dma_resp), 32'd0);
    tick();

    // WS=3 write of 0x1234 to 0x0200
    per_wr(3'd4, 16'h0003);
    dma_en = 1'b1; dma_we = 2'b11; dma_din = 16'h1234; dma_addr = 15'h0100;
    for (int i = 0; i < 4; i++) begin
      @(negedge mclk);
      check("ws3_ready", 32'(dma_ready), 32'(i == 3));
      if (i == 3) begin
        check("ws3_cen",  32'(dmem_cen),  32'd0);
        check("ws3_wen",  32'(dmem_wen),  32'd0);
        check("ws3_addr", 32'(dmem_addr), 32'd0);
        check("ws3_din",  32'(dmem_din),  32'h1234);
      end
      tick();
    end
    dma_en = 1'b0; dma_we = 2'b00;
    per_rd(3'd6, rd);
    check("ws3_stall", 32'(rd), 32'd3);

    // access window [0x0200, 0x0210)
    per_wr(3'd0, 16'h0200);
    per_wr(3'd2, 16'h0210);
    per_wr(3'd4, 16'h0010);
    per_rd(3'd4, rd);
    check("ctrl_rd", 32'(rd), 32'h0010);
    dma_rd(16'h0200, s_rdy, s_cen, s_resp, s_dout);
    check("win_lo_cen",  32'(s_cen),  32'd0);
    check("win_lo_dout", 32'(s_dout), 32'h1234);
    dma_rd(16'h020E, s_rdy, s_cen, s_resp, s_dout);
    check("win_top_cen", 32'(s_cen), 32'd0);
    dma_rd(16'h0210, s_rdy, s_cen, s_resp, s_dout);
    check("win_hi_rdy",  32'(s_rdy),  32'd1);
    check("win_hi_cen",  32'(s_cen),  32'd1);
    check("win_hi_resp", 32'(s_resp), 32'd1);
    check("win_hi_dout", 32'(s_dout), 32'd0);
    @(negedge mclk);
    check("win_resp_1cyc", 32'(dma_resp), 32'd0);
    tick();
    // RAM range limits with the window disabled
    per_wr(3'd4, 16'h0000);
    dma_rd(16'h01FE, s_rdy, s_cen, s_resp, s_dout);
    check("rng_lo_cen",  32'(s_cen),  32'd1);
    check("rng_lo_resp", 32'(s_resp), 32'd1);
    dma_rd(16'h0A00, s_rdy, s_cen, s_resp, s_dout);
    check("rng_hi_resp", 32'(s_resp), 32'd1);
    dma_rd(16'h09FE, s_rdy, s_cen, s_resp, s_dout);
    check("rng_top_cen",  32'(s_cen),  32'd0);
    check("rng_top_resp", 32'(s_resp), 32'd0);

    // CPU contention for 5 cycles, then priority override
    per_wr(3'd6, 16'h0000);
    cpu_dmem_busy = 1'b1; dma_priority = 1'b0;
    dma_en = 1'b1; dma_addr = 15'h0102;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) cpu_dmem_busy = 1'b0;
      @(negedge mclk);
      check("busy_ready", 32'(dma_ready), 32'(i == 5));
      tick();
    end
    dma_en = 1'b0;
    per_rd(3'd6, rd);
    check("busy_stall", 32'(rd), 32'd5);
    cpu_dmem_busy = 1'b1; dma_priority = 1'b1; dma_en = 1'b1;
    @(negedge mclk);
    check("prio_ready", 32'(dma_ready), 32'd1);
    check("prio_cen",   32'(dmem_cen),  32'd0);
    tick();
    dma_en = 1'b0; cpu_dmem_busy = 1'b0; dma_priority = 1'b0;
    tick();

    // WS=6 request aborted after 2 cycles
    per_wr(3'd6, 16'h0000);
    per_wr(3'd4, 16'h0006);
    dma_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge mclk);
      check("abort_cen", 32'(dmem_cen), 32'd1);
      tick();
    end
    dma_en = 1'b0;
    @(negedge mclk);
    check("abort_cen2", 32'(dmem_cen), 32'd1);
    check("abort_resp", 32'(dma_resp), 32'd0);
    tick();
    // a fresh request must see the full 6 wait states again
    dma_en = 1'b1;
    cycles = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge mclk);
      if (dma_ready) break;
      cycles++;
      tick();
    end
    check("ws6_latency", 32'(cycles), 32'd6);
    tick();
    dma_en = 1'b0;
    tick();
    per_rd(3'd6, rd);
    check("abort_stall", 32'(rd), 32'd8);

    // reset asserted mid-WAIT
    dma_en = 1'b1;
    tick(); tick();
    puc_rst = 1'b1;
    #1;
    check("mid_rst_ready", 32'(dma_ready), 32'd0);
    check("mid_rst_cen",   32'(dmem_cen),  32'd1);
    check("mid_rst_wen",   32'(dmem_wen),  32'd3);
    check("mid_rst_resp",  32'(dma_resp),  32'd0);
    check("mid_rst_dout",  32'(dma_dout),  32'd0);
    dma_en = 1'b0;
    tick();
    puc_rst = 1'b0;
    tick();
    per_rd(3'd4, rd);
    check("mid_rst_ctrl", 32'(rd), 32'd0);
    per_rd(3'd2, rd);
    check("mid_rst_winhi", 32'(rd), 32'hFFFF);

    // STALL saturation and clear
    cpu_dmem_busy = 1'b1; dma_en = 1'b1;
    repeat (70000) @(posedge mclk);
    #1;
    dma_en = 1'b0; cpu_dmem_busy = 1'b0;
    tick();
    per_rd(3'd6, rd);
    check("stall_sat", 32'(rd), 32'hFFFF);
    per_wr(3'd6, 16'h0000);
    per_rd(3'd6, rd);
    check("stall_clr", 32'(rd), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
